// File: rtl/conv_filter_grad.sv
// Backward-pass engine for one convolution filter.
// Accumulates dW[k] = sum_p dY[p]*X[window(p)+k] and db = sum_p dY[p]
// over a raster-ordered stream of output gradients, one tap per cycle.
// All values are signed fixed point with frac_bits fractional bits.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; X buffer writable
// WAIT_DY | dy_ready high, waiting for the next output gradient
// MAC     | one tap per cycle: dW[k] += (dy_reg * X[...]) >>> frac_bits
// DONE    | one-cycle done pulse, then back to IDLE
module conv_filter_grad #(
    parameter int input_size  = 28,
    parameter int filter_size = 7,
    parameter int stride      = 2,
    parameter int frac_bits   = 16,
    localparam int out_size   = (input_size - filter_size) / stride + 1,
    localparam int num_pos    = out_size * out_size,
    localparam int num_taps   = filter_size * filter_size,
    localparam int xa_w       = $clog2(input_size * input_size),
    localparam int ka_w       = $clog2(num_taps)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            x_wr_en,
    input  logic [xa_w-1:0] x_wr_addr,
    input  logic [31:0]     x_wr_data,
    input  logic            dy_valid,
    input  logic [31:0]     dy_data,
    output logic            dy_ready,
    input  logic [ka_w-1:0] dw_rd_addr,
    output logic [31:0]     dw_rd_data,
    output logic [31:0]     db_out,
    output logic            busy,
    output logic            done
);

    localparam int num_x = input_size * input_size;
    localparam int ow    = $clog2(out_size + 1);
    localparam int kw    = $clog2(num_taps + 1);
    localparam int fw    = $clog2(filter_size + 1);

    typedef enum logic [1:0] {IDLE, WAIT_DY, MAC, DONE} state_t;

    state_t state, state_next;

    logic [31:0]     x_mem [num_x];
    logic [31:0]     dw [num_taps];
    logic [31:0]     db;
    logic [31:0]     dy_reg;
    logic [ow-1:0]   oy, ox;
    logic [kw-1:0]   k;
    logic [fw-1:0]   ky, kx;
    logic            last_tap, last_pos;
    logic [xa_w-1:0] x_idx;
    logic [31:0]     x_val;
    logic [63:0]     dy_ext, x_ext;
    logic signed [63:0] prod;
    logic [31:0]     tap_p;

    assign last_tap = (k == kw'(num_taps - 1));
    assign last_pos = (oy == ow'(out_size - 1)) && (ox == ow'(out_size - 1));
    assign db_out   = db;

    // Window address, full 64-bit signed product, arithmetic shift and truncation to 32 bits
    always_comb begin
        x_idx  = xa_w'((int'(oy) * stride + int'(ky)) * input_size
                       + int'(ox) * stride + int'(kx));
        x_val  = x_mem[x_idx];
        dy_ext = {{32{dy_reg[31]}}, dy_reg};
        x_ext  = {{32{x_val[31]}}, x_val};
        prod   = $signed(dy_ext) * $signed(x_ext);
        tap_p  = 32'(prod >>> frac_bits);
    end

    // Combinational dW read port; out-of-range taps read as zero
    always_comb begin
        dw_rd_data = '0;
        if (int'(dw_rd_addr) < num_taps) begin
            dw_rd_data = dw[dw_rd_addr];
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and state-decoded outputs; dy_ready depends on state only
    always_comb begin
        state_next = state;
        dy_ready   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = WAIT_DY;
            end
            WAIT_DY: begin
                dy_ready = 1'b1;
                if (dy_valid) state_next = MAC;
            end
            MAC: begin
                if (last_tap) state_next = last_pos ? DONE : WAIT_DY;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // X buffer, accumulators and window counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < num_x; i++) x_mem[i] <= '0;
            for (int i = 0; i < num_taps; i++) dw[i] <= '0;
            db     <= '0;
            dy_reg <= '0;
            oy     <= '0;
            ox     <= '0;
            k      <= '0;
            ky     <= '0;
            kx     <= '0;
        end else begin
            // a write in the same cycle as start is still honoured: busy is low in IDLE
            if (state == IDLE && x_wr_en && int'(x_wr_addr) < num_x) begin
                x_mem[x_wr_addr] <= x_wr_data;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < num_taps; i++) dw[i] <= '0;
                        db <= '0;
                        oy <= '0;
                        ox <= '0;
                        k  <= '0;
                        ky <= '0;
                        kx <= '0;
                    end
                end
                WAIT_DY: begin
                    if (dy_valid) begin
                        dy_reg <= dy_data;
                        db     <= db + dy_data;
                        k      <= '0;
                        ky     <= '0;
                        kx     <= '0;
                    end
                end
                MAC: begin
                    dw[k] <= dw[k] + tap_p;
                    if (last_tap) begin
                        k  <= '0;
                        ky <= '0;
                        kx <= '0;
                        if (!last_pos) begin
                            if (ox == ow'(out_size - 1)) begin
                                ox <= '0;
                                oy <= oy + 1'b1;
                            end else begin
                                ox <= ox + 1'b1;
                            end
                        end
                    end else begin
                        k <= k + 1'b1;
                        if (kx == fw'(filter_size - 1)) begin
                            kx <= '0;
                            ky <= ky + 1'b1;
                        end else begin
                            kx <= kx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_filter_grad.sv
// Bench for conv_filter_grad on a 4x4 map, 2x2 filter, stride 2.
// Stimulus pushes expected dW/db into a scoreboard queue; a monitor pops
// and compares whenever done pulses (or a snapshot is requested).
module tb_conv_filter_grad;

    localparam int NK = 4;

    typedef struct packed {
        logic [3:0][31:0] dw;
        logic [31:0]      db;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        x_wr_en = 1'b0;
    logic [3:0]  x_wr_addr = '0;
    logic [31:0] x_wr_data = '0;
    logic        dy_valid = 1'b0;
    logic [31:0] dy_data = '0;
    logic        dy_ready;
    logic [1:0]  dw_rd_addr = '0;
    logic [31:0] dw_rd_data;
    logic [31:0] db_out;
    logic        busy;
    logic        done;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   mac_left = 0;
    int   res_idx = 0;
    logic snap_req = 1'b0;
    exp_t sb[$];

    logic [31:0] win [16];
    logic [31:0] fill [16];

    conv_filter_grad #(
        .input_size(4), .filter_size(2), .stride(2), .frac_bits(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .x_wr_en(x_wr_en), .x_wr_addr(x_wr_addr), .x_wr_data(x_wr_data),
        .dy_valid(dy_valid), .dy_data(dy_data), .dy_ready(dy_ready),
        .dw_rd_addr(dw_rd_addr), .dw_rd_data(dw_rd_data),
        .db_out(db_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] c, input logic [31:0] d,
                                input logic [31:0] dbv);
        exp_t e;
        e.dw[0] = a;
        e.dw[1] = b;
        e.dw[2] = c;
        e.dw[3] = d;
        e.db    = dbv;
        return e;
    endfunction

    // Monitor: dy_ready must stay low for NK cycles after each accept; results checked on done/snapshot
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            mac_left = 0;
        end else if (mac_left > 0) begin
            chk("ready_in_mac", {31'b0, dy_ready}, 32'd0);
            mac_left--;
        end
        if (rst_n && dy_valid && dy_ready) mac_left = NK;
        if (done || snap_req) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got done=%0b snap=%0b want no result", done, snap_req);
            end else begin
                e = sb.pop_front();
                for (int i = 0; i < 4; i++) begin
                    dw_rd_addr = 2'(i);
                    #1;
                    chk($sformatf("res%0d_dw%0d", res_idx, i), dw_rd_data, e.dw[i]);
                end
                chk($sformatf("res%0d_db", res_idx), db_out, e.db);
            end
            res_idx++;
        end
    end

    task automatic load_x(input logic [31:0] v [16]);
        for (int i = 0; i < 16; i++) begin
            x_wr_en   = 1'b1;
            x_wr_addr = 4'(i);
            x_wr_data = v[i];
            @(posedge clk); #1;
        end
        x_wr_en = 1'b0;
    endtask

    task automatic feed(input logic [31:0] dys [4], input int n, input bit gaps, input bit disturb);
        int t;
        for (int i = 0; i < n; i++) begin
            if (disturb) begin
                start     = 1'b1;
                x_wr_en   = 1'b1;
                x_wr_addr = 4'd0;
                x_wr_data = 32'h00ff0000;
            end
            if (gaps) begin
                dy_valid = 1'b0;
                repeat ($urandom_range(0, 7)) begin
                    @(posedge clk); #1;
                end
            end
            dy_data  = dys[i];
            dy_valid = 1'b1;
            t = 0;
            while (!dy_ready && t < 100) begin
                @(posedge clk); #1;
                t++;
            end
            start   = 1'b0;
            x_wr_en = 1'b0;
            if (!dy_ready) begin
                total++;
                bad++;
                $display("FAIL dy_ready_timeout: got 0 want 1");
            end
            @(posedge clk); #1;
        end
        dy_valid = 1'b0;
    endtask

    task automatic run_pass(input string name, input logic [31:0] dys [4],
                            input bit gaps, input bit disturb, input exp_t e);
        int st;
        int t;
        sb.push_back(e);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        st = cyc;
        feed(dys, 4, gaps, disturb);
        t = 0;
        while (!done && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s_done_timeout: got done=0 want 1", name);
        end else begin
            if (!gaps) chk({name, "_latency"}, 32'(cyc - st), 32'd20);
            chk({name, "_busy_in_done"}, {31'b0, busy}, 32'd1);
            @(posedge clk); #1;
            chk({name, "_busy_after"}, {31'b0, busy}, 32'd0);
            chk({name, "_done_after"}, {31'b0, done}, 32'd0);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic fill_x(input logic [31:0] v);
        for (int i = 0; i < 16; i++) fill[i] = v;
        load_x(fill);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) win[i] = 32'(i) << 16;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_dy_ready", {31'b0, dy_ready}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        sb.push_back(mk(32'd0, 32'd0, 32'd0, 32'd0, 32'd0));
        snap_req = 1'b1;
        @(negedge clk); @(posedge clk); #1;
        snap_req = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // basic: all ones
        fill_x(32'h00010000);
        run_pass("basic", '{32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000}, 1'b0, 1'b0,
                 mk(32'h00040000, 32'h00040000, 32'h00040000, 32'h00040000, 32'h00040000));

        // sign: 3.0 * -0.5 four times
        fill_x(32'h00030000);
        run_pass("sign", '{32'hFFFF8000, 32'hFFFF8000, 32'hFFFF8000, 32'hFFFF8000}, 1'b0, 1'b0,
                 mk(32'hFFFA0000, 32'hFFFA0000, 32'hFFFA0000, 32'hFFFA0000, 32'hFFFE0000));

        // truncation toward minus infinity
        fill_x(32'h00000001);
        run_pass("trunc_pos", '{32'h00008000, 32'h00008000, 32'h00008000, 32'h00008000}, 1'b0, 1'b0,
                 mk(32'h0, 32'h0, 32'h0, 32'h0, 32'h00020000));
        run_pass("trunc_neg", '{32'hFFFF8000, 32'hFFFF8000, 32'hFFFF8000, 32'hFFFF8000}, 1'b0, 1'b0,
                 mk(32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFE0000));

        // window indexing
        load_x(win);
        run_pass("win_first", '{32'h00010000, 32'h0, 32'h0, 32'h0}, 1'b0, 1'b0,
                 mk(32'h00000000, 32'h00010000, 32'h00040000, 32'h00050000, 32'h00010000));
        run_pass("win_last", '{32'h0, 32'h0, 32'h0, 32'h00010000}, 1'b0, 1'b0,
                 mk(32'h000A0000, 32'h000B0000, 32'h000E0000, 32'h000F0000, 32'h00010000));

        // backpressure and ignored start / x writes while busy
        run_pass("ones_ref", '{32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000}, 1'b0, 1'b0,
                 mk(32'h00140000, 32'h00180000, 32'h00240000, 32'h00280000, 32'h00040000));
        run_pass("gaps", '{32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000}, 1'b1, 1'b1,
                 mk(32'h00140000, 32'h00180000, 32'h00240000, 32'h00280000, 32'h00040000));
        run_pass("x_kept", '{32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000}, 1'b0, 1'b0,
                 mk(32'h00140000, 32'h00180000, 32'h00240000, 32'h00280000, 32'h00040000));
        repeat (10) @(posedge clk);
        #1;
        chk("no_extra_pass", {31'b0, busy}, 32'd0);

        // reset during the third position's MAC
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        feed('{32'h00010000, 32'h00010000, 32'h00010000, 32'h0}, 3, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_dy_ready", {31'b0, dy_ready}, 32'd0);
        chk("midrst_db", db_out, 32'd0);
        sb.push_back(mk(32'd0, 32'd0, 32'd0, 32'd0, 32'd0));
        snap_req = 1'b1;
        @(negedge clk); @(posedge clk); #1;
        snap_req = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        load_x(win);
        run_pass("after_rst", '{32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000}, 1'b0, 1'b0,
                 mk(32'h00140000, 32'h00180000, 32'h00240000, 32'h00280000, 32'h00040000));

        repeat (5) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
